// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
// Funct3 encodings, FSM states and an access-size helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Access size in bytes from the low funct3 bits.
    function automatic logic [3:0] size_w(input logic [2:0] f3);
        unique case (f3[1:0])
            2'b00:   size_w = 4'd1;
            2'b01:   size_w = 4'd2;
            2'b10:   size_w = 4'd4;
            default: size_w = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for one doubleword of data memory.
// Builds byte enables, aligns store data, extracts and extends loads.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    input  logic [63:0] rdword,
    output logic [7:0]  be,
    output logic [63:0] wbytes,
    output logic [63:0] rval,
    output logic        misalign
);

    logic [3:0]  size;
    logic [7:0]  base_mask;
    logic [5:0]  sh;
    logic [63:0] shifted;

    assign size   = size_w(funct3);
    assign sh     = {addr, 3'b000};
    assign wbytes = wdata << sh;
    assign shifted = rdword >> sh;
    assign be     = base_mask << addr;

    // Size-dependent mask, alignment check and load extension.
    always_comb begin
        base_mask = 8'h00;
        misalign  = 1'b0;
        rval      = 64'd0;
        unique case (funct3[1:0])
            2'b00: begin
                base_mask = 8'h01;
                rval = funct3[2] ? {56'd0, shifted[7:0]}
                                 : {{56{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                base_mask = 8'h03;
                misalign  = addr[0];
                rval = funct3[2] ? {48'd0, shifted[15:0]}
                                 : {{48{shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                base_mask = 8'h0F;
                misalign  = |addr[1:0];
                rval = funct3[2] ? {32'd0, shifted[31:0]}
                                 : {{32{shifted[31]}}, shifted[31:0]};
            end
            default: begin
                base_mask = 8'hFF;
                misalign  = |addr;
                rval      = shifted;
            end
        endcase
        if (size == 4'd0) base_mask = 8'h00;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory behind a valid/ready request/response pair.
// Optional macro DMEM_PROBE_EN exposes doublewords 0..3 as probe0..probe3.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PROBE_EN
    ,
    output logic [63:0] probe0,
    output logic [63:0] probe1,
    output logic [63:0] probe2,
    output logic [63:0] probe3
`endif
);

    localparam int DW_N = DEPTH_BYTES / 8;
    localparam int IW   = (DW_N > 1) ? $clog2(DW_N) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t state;
    logic [3:0]  cnt;
    logic        cap_write;
    logic [63:0] cap_addr;
    logic [2:0]  cap_funct3;
    logic [63:0] cap_wdata;

    logic [63:0] mem [DW_N];

    logic        op_write;
    logic [63:0] op_addr;
    logic [2:0]  op_funct3;
    logic [63:0] op_wdata;
    logic [63:0] dw_sel;
    logic [IW-1:0] idx;
    logic [7:0]  be;
    logic [63:0] wbytes;
    logic [63:0] rval;
    logic        misalign;
    logic        illegal;
    logic        out_of_range;
    logic        acc_err;
    logic [63:0] acc_rdata;
    logic        do_access;
    logic        do_write;

    // With LATENCY=1 the access happens on the accepting edge itself,
    // so the operands come straight from the request port in IDLE.
    assign op_write  = (state == ST_IDLE) ? req_write  : cap_write;
    assign op_addr   = (state == ST_IDLE) ? req_addr   : cap_addr;
    assign op_funct3 = (state == ST_IDLE) ? req_funct3 : cap_funct3;
    assign op_wdata  = (state == ST_IDLE) ? req_wdata  : cap_wdata;

    assign dw_sel = op_addr >> 3;
    assign idx    = dw_sel[IW-1:0];

    dmem_lane u_lane (
        .addr     (op_addr[2:0]),
        .funct3   (op_funct3),
        .wdata    (op_wdata),
        .rdword   (mem[idx]),
        .be       (be),
        .wbytes   (wbytes),
        .rval     (rval),
        .misalign (misalign)
    );

    assign illegal = (op_funct3 == 3'b111) || (op_write && op_funct3[2]);
    assign out_of_range = ({1'b0, op_addr} + 65'(size_w(op_funct3)))
                          > 65'(DEPTH_BYTES);
    assign acc_err   = illegal || misalign || out_of_range;
    assign acc_rdata = (acc_err || op_write) ? 64'd0 : rval;

    assign do_access = (state == ST_BUSY && cnt == 4'd0) ||
                       (LATENCY == 1 && state == ST_IDLE && req_valid);
    assign do_write  = do_access && op_write && !acc_err;

    assign req_ready = (state == ST_IDLE) && reset;

`ifdef DMEM_PROBE_EN
    assign probe0 = mem[0];
    assign probe1 = mem[1];
    assign probe2 = mem[2];
    assign probe3 = mem[3];
`endif

    // Request capture, latency countdown and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            cap_write  <= 1'b0;
            cap_addr   <= 64'd0;
            cap_funct3 <= 3'd0;
            cap_wdata  <= 64'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_write  <= req_write;
                        cap_addr   <= req_addr;
                        cap_funct3 <= req_funct3;
                        cap_wdata  <= req_wdata;
                        cnt        <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= acc_rdata;
                            rsp_err   <= acc_err;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= acc_rdata;
                        rsp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 64'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage: cleared by reset, byte-enabled writes on the access edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DW_N; i++) mem[i] <= 64'd0;
        end else if (do_write) begin
            for (int k = 0; k < 8; k++) begin
                if (be[k]) mem[idx][k*8 +: 8] <= wbytes[k*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Works with or without DMEM_PROBE_EN defined.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_PROBE_EN
    logic [63:0] probe0, probe1, probe2, probe3;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef DMEM_PROBE_EN
        ,
        .probe0     (probe0),
        .probe1     (probe1),
        .probe2     (probe2),
        .probe3     (probe3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; entered and left #1 after a rising edge.
    task automatic xact(input logic w, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] er, input logic ee,
                        input string tag);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd2);
        chk({tag, "_rdata"}, rsp_rdata, er);
        chk({tag, "_err"}, 64'(rsp_err), 64'(ee));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] hold_d;
        logic        hold_e;
        int n;

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        xact(1'b0, 3'b011, 64'd0, 64'd0, 64'd0, 1'b0, "ld0_reset");

        // 2. SD/LD round trip
        xact(1'b1, 3'b011, 64'd8, 64'h1122334455667788, 64'd0, 1'b0, "sd8");
        xact(1'b0, 3'b011, 64'd8, 64'd0, 64'h1122334455667788, 1'b0, "ld8");

        // 3. sub-word extension
        xact(1'b0, 3'b000, 64'd8, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0, "lb8");
        xact(1'b0, 3'b100, 64'd8, 64'd0, 64'h88, 1'b0, "lbu8");
        xact(1'b0, 3'b001, 64'd10, 64'd0, 64'h5566, 1'b0, "lh10");
        xact(1'b0, 3'b110, 64'd12, 64'd0, 64'h11223344, 1'b0, "lwu12");
        xact(1'b0, 3'b010, 64'd12, 64'd0, 64'h11223344, 1'b0, "lw12");
        xact(1'b1, 3'b001, 64'd14, 64'h0000_0000_0000_F00D, 64'd0, 1'b0,
             "sh14");
        xact(1'b0, 3'b010, 64'd12, 64'd0, 64'hFFFFFFFFF00D3344, 1'b0,
             "lw12_neg");

        // 4. errors
        xact(1'b0, 3'b010, 64'd6, 64'd0, 64'd0, 1'b1, "lw6_mis");
        xact(1'b1, 3'b011, 64'd248, 64'hCAFEBABEDEADBEEF, 64'd0, 1'b0,
             "sd248");
        xact(1'b1, 3'b011, 64'd256, 64'h0123456789ABCDEF, 64'd0, 1'b1,
             "sd256_oor");
        xact(1'b1, 3'b000, 64'hFFFFFFFFFFFFFFF8, 64'h55, 64'd0, 1'b1,
             "sb_wrap");
        xact(1'b1, 3'b100, 64'd16, 64'h77, 64'd0, 1'b1, "st_illegal");
        xact(1'b0, 3'b111, 64'd8, 64'd0, 64'd0, 1'b1, "ld_f3_111");
        xact(1'b0, 3'b011, 64'd248, 64'd0, 64'hCAFEBABEDEADBEEF, 1'b0,
             "ld248");
        xact(1'b0, 3'b000, 64'd16, 64'd0, 64'd0, 1'b0, "lb16_clean");
        xact(1'b0, 3'b100, 64'd255, 64'd0, 64'hCA, 1'b0, "lbu255");

        // 5. back-pressure
        req_valid = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 64'd15;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_latency", 64'(n), 64'd2);
        hold_d = rsp_rdata;
        hold_e = rsp_err;
        chk("bp_rdata", hold_d, 64'hFFFFFFFFFFFFFFF0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_d", rsp_rdata, hold_d);
            chk("bp_hold_e", 64'(rsp_err), 64'(hold_e));
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_done", 64'(rsp_valid), 64'd0);

        // 6. reset during BUSY
        req_valid = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 64'd0;
        req_wdata = 64'hAB;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_req_ready", 64'(req_ready), 64'd0);
`ifdef DMEM_PROBE_EN
        chk("mid_probe0", probe0, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef DMEM_PROBE_EN
            chk("post_probe0", probe0, 64'd0);
`endif
        end
        xact(1'b0, 3'b011, 64'd0, 64'd0, 64'd0, 1'b0, "ld0_after");
        xact(1'b0, 3'b011, 64'd8, 64'd0, 64'd0, 1'b0, "ld8_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
